// File: rtl/gpio_input_conditioner_if.sv
// Signal bundle between the pad-side GPIO inputs, the GPIO register block
// and the input conditioner. The conditioner takes the slave modport.
interface gpio_input_conditioner_if #(
    parameter int unsigned GPIO_WIDTH = 3
);
    logic [GPIO_WIDTH-1:0] gpio_raw;
    logic [GPIO_WIDTH-1:0] rise_enable;
    logic [GPIO_WIDTH-1:0] fall_enable;
    logic [GPIO_WIDTH-1:0] irq_clear;
    logic [GPIO_WIDTH-1:0] gpio_stable;
    logic [GPIO_WIDTH-1:0] irq_pending;
    logic                  irq;

    modport master (
        output gpio_raw,
        output rise_enable,
        output fall_enable,
        output irq_clear,
        input  gpio_stable,
        input  irq_pending,
        input  irq
    );

    modport slave (
        input  gpio_raw,
        input  rise_enable,
        input  fall_enable,
        input  irq_clear,
        output gpio_stable,
        output irq_pending,
        output irq
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-pin two-flop synchroniser, counter debouncer and edge detector feeding
// sticky write-1-to-clear interrupt-pending bits.
module gpio_input_conditioner #(
    parameter int unsigned GPIO_WIDTH      = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    gpio_input_conditioner_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] stable_q;
    logic [GPIO_WIDTH-1:0] stable_d;
    logic [GPIO_WIDTH-1:0] pending_q;
    logic [GPIO_WIDTH-1:0] pending_d;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] set_pend;
    logic [CNT_W-1:0]      cnt_q [GPIO_WIDTH];
    logic [CNT_W-1:0]      cnt_d [GPIO_WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            pending_q <= '0;
            for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= bus.gpio_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Any cycle of agreement restarts the count; the count never passes CNT_LAST.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edges come from the debounced level only; a set beats a same-edge clear.
    always_comb begin
        rise      = stable_d & ~stable_q;
        fall      = ~stable_d & stable_q;
        set_pend  = (rise & bus.rise_enable) | (fall & bus.fall_enable);
        pending_d = set_pend | (pending_q & ~bus.irq_clear);
    end

    assign bus.gpio_stable = stable_q;
    assign bus.irq_pending = pending_q;
    assign bus.irq         = |pending_q;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner (3 pins, 4-cycle debounce) with a
// queue of expected output snapshots compared at the falling clock edge.
module tb_gpio_input_conditioner;
    localparam int unsigned W = 3;

    typedef struct {
        string        tag;
        logic [W-1:0] stable;
        logic [W-1:0] pending;
        logic         irq;
    } exp_t;

    logic clock;
    logic clk_en;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    gpio_input_conditioner_if #(.GPIO_WIDTH(W)) bus ();

    gpio_input_conditioner #(
        .GPIO_WIDTH     (W),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever begin
            #5;
            if (clk_en) clock = ~clock;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] s, input logic [W-1:0] p);
        exp_t e;
        e.tag     = tag;
        e.stable  = s;
        e.pending = p;
        e.irq     = |p;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (bus.gpio_stable === e.stable) else begin
                errors++;
                $error("FAIL %s gpio_stable: got %b expected %b", e.tag, bus.gpio_stable, e.stable);
            end
            checks++;
            assert (bus.irq_pending === e.pending) else begin
                errors++;
                $error("FAIL %s irq_pending: got %b expected %b", e.tag, bus.irq_pending, e.pending);
            end
            checks++;
            assert (bus.irq === e.irq) else begin
                errors++;
                $error("FAIL %s irq: got %b expected %b", e.tag, bus.irq, e.irq);
            end
        end
    endtask

    task automatic step(input string tag, input int n, input logic [W-1:0] s, input logic [W-1:0] p);
        expect_out(tag, s, p);
        cycles(n);
        check_out();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        clk_en          = 1'b0;
        reset_n         = 1'b1;
        bus.gpio_raw    = 3'b111;
        bus.rise_enable = 3'b000;
        bus.fall_enable = 3'b000;
        bus.irq_clear   = 3'b000;

        // 1. reset with no clock running
        #2 reset_n = 1'b0;
        expect_out("reset_noclk", 3'b000, 3'b000);
        #1 check_out();
        bus.gpio_raw = 3'b000;
        clk_en = 1'b1;
        cycles(3);
        reset_n = 1'b1;
        step("idle", 3, 3'b000, 3'b000);

        // 2. clean rise on pin 0
        bus.gpio_raw    = 3'b001;
        bus.rise_enable = 3'b001;
        step("rise_edge5", 5, 3'b000, 3'b000);
        step("rise_edge6", 1, 3'b001, 3'b001);

        // 3. 3-cycle glitch on pin 1 is rejected
        bus.rise_enable = 3'b011;
        bus.gpio_raw    = 3'b011;
        cycles(3);
        bus.gpio_raw    = 3'b001;
        for (int k = 0; k < 6; k++) step("glitch", 1, 3'b001, 3'b001);
        bus.irq_clear = 3'b001;
        step("clear_pin0", 1, 3'b001, 3'b000);
        bus.irq_clear = 3'b000;

        // 4. fall on pin 2 with simultaneous clear
        bus.rise_enable = 3'b001;
        bus.gpio_raw    = 3'b101;
        step("pin2_high", 6, 3'b101, 3'b000);
        bus.fall_enable = 3'b100;
        bus.gpio_raw    = 3'b001;
        step("fall_edge5", 5, 3'b101, 3'b000);
        bus.irq_clear = 3'b100;
        step("fall_race", 1, 3'b001, 3'b100);
        bus.irq_clear = 3'b000;
        step("fall_hold", 2, 3'b001, 3'b100);
        bus.irq_clear = 3'b100;
        step("lone_clear", 1, 3'b001, 3'b000);
        bus.irq_clear = 3'b000;

        // 5. disabled rise, enabled afterwards
        bus.rise_enable = 3'b000;
        bus.gpio_raw    = 3'b000;
        step("pin0_low", 6, 3'b000, 3'b000);
        bus.gpio_raw = 3'b001;
        step("dis_rise", 6, 3'b001, 3'b000);
        bus.rise_enable = 3'b001;
        step("late_enable", 3, 3'b001, 3'b000);

        // 6. async reset in the middle of a pin 1 debounce
        bus.rise_enable = 3'b010;
        bus.gpio_raw    = 3'b011;
        step("pre_reset", 4, 3'b001, 3'b000);
        reset_n = 1'b0;
        expect_out("async_reset", 3'b000, 3'b000);
        #1 check_out();
        cycles(1);
        reset_n = 1'b1;
        step("rst_edge5", 5, 3'b000, 3'b000);
        step("rst_edge6", 1, 3'b011, 3'b010);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
